// File: rtl/pwr_axil_write_arb.sv
// pwr_axil_write_arb
//
// Arbitrates single-beat AXI-Lite writes between two requesters: the power
// sequencer ("maestro", higher priority) and the observation-forwarding FSM.
// Each requester raises a rising edge on its req line. The arbiter latches the
// address/data, issues one AW/W beat, waits for the B response and returns a
// one-cycle ack qualified by valid (1 = OKAY). Only one write is in flight at
// a time.
//
// Ports
//   clk, rst_n                     clock, synchronous active-low reset
//   maestro_adress_i/data_i/req_i  maestro write request (edge triggered)
//   maestro_ack_o/valid_o          maestro completion pulse / OKAY qualifier
//   fsm_adress_i/data_i/req_i      fsm write request (edge triggered)
//   fsm_ack_o/valid_o              fsm completion pulse / OKAY qualifier
//   aw_*, w_*, b_*                 AXI-Lite write channels (manager side)
//   err_o                          sticky: some write failed or timed out
module pwr_axil_write_arb #(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned RESP_TIMEOUT = 256
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [ADDR_W-1:0]   maestro_adress_i,
  input  logic [DATA_W-1:0]   maestro_data_i,
  input  logic                maestro_req_i,
  output logic                maestro_ack_o,
  output logic                maestro_valid_o,
  input  logic [ADDR_W-1:0]   fsm_adress_i,
  input  logic [DATA_W-1:0]   fsm_data_i,
  input  logic                fsm_req_i,
  output logic                fsm_ack_o,
  output logic                fsm_valid_o,
  output logic [ADDR_W-1:0]   aw_addr,
  output logic [2:0]          aw_prot,
  output logic                aw_valid,
  input  logic                aw_ready,
  output logic [DATA_W-1:0]   w_data,
  output logic [DATA_W/8-1:0] w_strb,
  output logic                w_valid,
  input  logic                w_ready,
  input  logic [1:0]          b_resp,
  input  logic                b_valid,
  output logic                b_ready,
  output logic                err_o
);

  // Counter must hold RESP_TIMEOUT itself; a disabled timeout still needs a 1-bit counter.
  localparam int unsigned    CntW    = (RESP_TIMEOUT > 0) ? $clog2(RESP_TIMEOUT + 1) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(RESP_TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StAddr, StResp, StAck} state_e;

  state_e            state_q;
  logic              m_req_q, f_req_q;
  logic              m_pend_q, f_pend_q;
  logic [ADDR_W-1:0] m_addr_q, f_addr_q;
  logic [DATA_W-1:0] m_data_q, f_data_q;
  logic              gnt_q;  // 0 = maestro, 1 = fsm
  logic [CntW-1:0]   cnt_q;

  logic m_edge, f_edge;
  logic m_grant, f_grant;
  logic aw_fin, w_fin;
  logic resp_fire, resp_ok, resp_timeout;

  assign m_edge  = maestro_req_i & ~m_req_q;
  assign f_edge  = fsm_req_i & ~f_req_q;

  // Maestro wins when both are pending.
  assign m_grant = (state_q == StIdle) & m_pend_q;
  assign f_grant = (state_q == StIdle) & ~m_pend_q & f_pend_q;

  // A channel is finished when it already dropped valid or handshakes now.
  assign aw_fin  = ~aw_valid | aw_ready;
  assign w_fin   = ~w_valid | w_ready;

  assign resp_fire    = b_valid & b_ready;
  assign resp_ok      = resp_fire & (b_resp == 2'b00);
  // The last counted RESP cycle without b_valid ends the wait.
  assign resp_timeout = (RESP_TIMEOUT != 0) && (cnt_q == CntLast);

  assign aw_prot = 3'b000;
  assign w_strb  = '1;

  // Request capture runs in every FSM state. A fresh edge beats a same-cycle
  // grant so that request is not lost.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      m_req_q  <= 1'b0;
      f_req_q  <= 1'b0;
      m_pend_q <= 1'b0;
      f_pend_q <= 1'b0;
      m_addr_q <= '0;
      m_data_q <= '0;
      f_addr_q <= '0;
      f_data_q <= '0;
    end else begin
      m_req_q <= maestro_req_i;
      f_req_q <= fsm_req_i;
      if (m_edge) begin
        m_pend_q <= 1'b1;
        m_addr_q <= maestro_adress_i;
        m_data_q <= maestro_data_i;
      end else if (m_grant) begin
        m_pend_q <= 1'b0;
      end
      if (f_edge) begin
        f_pend_q <= 1'b1;
        f_addr_q <= fsm_adress_i;
        f_data_q <= fsm_data_i;
      end else if (f_grant) begin
        f_pend_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q         <= StIdle;
      gnt_q           <= 1'b0;
      cnt_q           <= '0;
      aw_addr         <= '0;
      aw_valid        <= 1'b0;
      w_data          <= '0;
      w_valid         <= 1'b0;
      b_ready         <= 1'b0;
      maestro_ack_o   <= 1'b0;
      maestro_valid_o <= 1'b0;
      fsm_ack_o       <= 1'b0;
      fsm_valid_o     <= 1'b0;
      err_o           <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (m_grant || f_grant) begin
            gnt_q    <= f_grant;
            aw_addr  <= f_grant ? f_addr_q : m_addr_q;
            w_data   <= f_grant ? f_data_q : m_data_q;
            aw_valid <= 1'b1;
            w_valid  <= 1'b1;
            state_q  <= StAddr;
          end
        end
        StAddr: begin
          if (aw_fin && w_fin) begin
            aw_valid <= 1'b0;
            w_valid  <= 1'b0;
            b_ready  <= 1'b1;
            cnt_q    <= '0;
            state_q  <= StResp;
          end else begin
            if (aw_valid && aw_ready) aw_valid <= 1'b0;
            if (w_valid && w_ready)   w_valid  <= 1'b0;
          end
        end
        StResp: begin
          if (resp_fire || resp_timeout) begin
            b_ready <= 1'b0;
            if (gnt_q) begin
              fsm_ack_o   <= 1'b1;
              fsm_valid_o <= resp_ok;
            end else begin
              maestro_ack_o   <= 1'b1;
              maestro_valid_o <= resp_ok;
            end
            if (!resp_ok) err_o <= 1'b1;
            state_q <= StAck;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StAck: begin
          maestro_ack_o   <= 1'b0;
          maestro_valid_o <= 1'b0;
          fsm_ack_o       <= 1'b0;
          fsm_valid_o     <= 1'b0;
          state_q         <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_pwr_axil_write_arb.sv
// Self-checking bench for pwr_axil_write_arb (RESP_TIMEOUT = 4).
module tb_pwr_axil_write_arb;

  logic        clk;
  logic        rst_n;
  logic [31:0] maestro_adress_i, maestro_data_i;
  logic        maestro_req_i, maestro_ack_o, maestro_valid_o;
  logic [31:0] fsm_adress_i, fsm_data_i;
  logic        fsm_req_i, fsm_ack_o, fsm_valid_o;
  logic [31:0] aw_addr;
  logic [2:0]  aw_prot;
  logic        aw_valid, aw_ready;
  logic [31:0] w_data;
  logic [3:0]  w_strb;
  logic        w_valid, w_ready;
  logic [1:0]  b_resp;
  logic        b_valid, b_ready;
  logic        err_o;

  int tests = 0;
  int fails = 0;
  int viol  = 0;

  // Slave behaviour knobs
  bit         tie = 0;
  bit         b_hang = 0;
  int         aw_delay = 0, w_delay = 0, b_delay = 0;
  logic [1:0] resp_cfg = 2'b00;

  // Observed traffic
  logic [31:0] aw_q[$];
  logic [31:0] w_q[$];
  logic [1:0]  ack_q[$];  // {port (1 = fsm), valid}

  pwr_axil_write_arb #(
    .ADDR_W(32),
    .DATA_W(32),
    .RESP_TIMEOUT(4)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .maestro_adress_i(maestro_adress_i),
    .maestro_data_i  (maestro_data_i),
    .maestro_req_i   (maestro_req_i),
    .maestro_ack_o   (maestro_ack_o),
    .maestro_valid_o (maestro_valid_o),
    .fsm_adress_i    (fsm_adress_i),
    .fsm_data_i      (fsm_data_i),
    .fsm_req_i       (fsm_req_i),
    .fsm_ack_o       (fsm_ack_o),
    .fsm_valid_o     (fsm_valid_o),
    .aw_addr         (aw_addr),
    .aw_prot         (aw_prot),
    .aw_valid        (aw_valid),
    .aw_ready        (aw_ready),
    .w_data          (w_data),
    .w_strb          (w_strb),
    .w_valid         (w_valid),
    .w_ready         (w_ready),
    .b_resp          (b_resp),
    .b_valid         (b_valid),
    .b_ready         (b_ready),
    .err_o           (err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  // AXI-Lite slave and traffic monitor, all on the falling edge.
  int aw_wait = 0, w_wait = 0, b_wait = 0;
  always @(negedge clk) begin
    if (tie) begin
      aw_ready = 1'b1;
      w_ready  = 1'b1;
      b_valid  = 1'b1;
      b_resp   = 2'b00;
    end else begin
      if (aw_valid) begin aw_ready = (aw_wait >= aw_delay); aw_wait++; end
      else begin aw_ready = 1'b0; aw_wait = 0; end
      if (w_valid) begin w_ready = (w_wait >= w_delay); w_wait++; end
      else begin w_ready = 1'b0; w_wait = 0; end
      if (b_ready) begin
        b_valid = !b_hang && (b_wait >= b_delay);
        b_resp  = resp_cfg;
        b_wait++;
      end else begin
        b_valid = 1'b0;
        b_wait  = 0;
      end
    end
    if (rst_n) begin
      if (aw_valid && aw_ready) aw_q.push_back(aw_addr);
      if (w_valid && w_ready)   w_q.push_back(w_data);
      if (maestro_ack_o) ack_q.push_back({1'b0, maestro_valid_o});
      if (fsm_ack_o)     ack_q.push_back({1'b1, fsm_valid_o});
    end
    if (maestro_ack_o && fsm_ack_o) viol++;
    if (maestro_valid_o && !maestro_ack_o) viol++;
    if (fsm_valid_o && !fsm_ack_o) viol++;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_mon();
    aw_q.delete();
    w_q.delete();
    ack_q.delete();
  endtask

  task automatic wait_acks(input int n, input int budget, output bit hit);
    hit = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (ack_q.size() >= n) begin hit = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(3);
    tests++; if (aw_valid !== 1'b0) begin fails++; $display("FAIL rst_aw_valid: got %b want 0", aw_valid); end
    tests++; if (w_valid !== 1'b0) begin fails++; $display("FAIL rst_w_valid: got %b want 0", w_valid); end
    tests++; if (b_ready !== 1'b0) begin fails++; $display("FAIL rst_b_ready: got %b want 0", b_ready); end
    tests++; if ({maestro_ack_o, maestro_valid_o, fsm_ack_o, fsm_valid_o} !== 4'b0) begin
      fails++; $display("FAIL rst_acks: got %b%b%b%b want 0000", maestro_ack_o, maestro_valid_o,
                        fsm_ack_o, fsm_valid_o); end
    tests++; if (err_o !== 1'b0) begin fails++; $display("FAIL rst_err: got %b want 0", err_o); end
    tests++; if (aw_addr !== 32'h0) begin fails++; $display("FAIL rst_aw_addr: got %h want 0", aw_addr); end
    tests++; if (w_data !== 32'h0) begin fails++; $display("FAIL rst_w_data: got %h want 0", w_data); end
    tests++; if (aw_prot !== 3'b000) begin fails++; $display("FAIL aw_prot: got %b want 000", aw_prot); end
    tests++; if (w_strb !== 4'hf) begin fails++; $display("FAIL w_strb: got %h want f", w_strb); end
    rst_n = 1'b1;
    tick(2);
  endtask

  task automatic test_latency();
    tie = 1'b1;
    clear_mon();
    tick(1);
    maestro_adress_i = 32'h2000_0014;
    maestro_data_i   = 32'h2;
    maestro_req_i    = 1'b1;
    @(negedge clk);  // after E0
    tests++; if (aw_valid !== 1'b0) begin fails++; $display("FAIL lat_e0_aw_valid: got %b want 0", aw_valid); end
    @(negedge clk);  // after E1
    tests++; if ({aw_valid, w_valid} !== 2'b11) begin
      fails++; $display("FAIL lat_e1_valids: got %b%b want 11", aw_valid, w_valid); end
    tests++; if (aw_addr !== 32'h2000_0014) begin fails++; $display("FAIL lat_aw_addr: got %h want 20000014", aw_addr); end
    tests++; if (w_data !== 32'h2) begin fails++; $display("FAIL lat_w_data: got %h want 2", w_data); end
    @(negedge clk);  // after E2
    tests++; if ({b_ready, aw_valid, w_valid} !== 3'b100) begin
      fails++; $display("FAIL lat_e2: got b_ready/aw/w %b%b%b want 100", b_ready, aw_valid, w_valid); end
    @(negedge clk);  // after E3
    tests++; if ({maestro_ack_o, maestro_valid_o, fsm_ack_o} !== 3'b110) begin
      fails++; $display("FAIL lat_e3_ack: got m_ack/m_valid/f_ack %b%b%b want 110",
                        maestro_ack_o, maestro_valid_o, fsm_ack_o); end
    maestro_req_i = 1'b0;
    @(negedge clk);
    tests++; if (maestro_ack_o !== 1'b0) begin fails++; $display("FAIL lat_ack_width: got %b want 0", maestro_ack_o); end
    tick(2);
    tests++; if (aw_q.size() != 1 || w_q.size() != 1) begin
      fails++; $display("FAIL lat_beats: got aw=%0d w=%0d want 1 1", aw_q.size(), w_q.size()); end
    tie = 1'b0;
    tick(2);
  endtask

  task automatic test_priority();
    bit hit;
    aw_delay = 1; w_delay = 2; b_delay = 1; resp_cfg = 2'b00;
    clear_mon();
    @(negedge clk);
    maestro_adress_i = 32'hA000_0004; maestro_data_i = 32'h1111_2222; maestro_req_i = 1'b1;
    fsm_adress_i     = 32'hB000_0008; fsm_data_i     = 32'h3333_4444; fsm_req_i     = 1'b1;
    @(negedge clk);
    maestro_req_i = 1'b0; fsm_req_i = 1'b0;
    wait_acks(2, 80, hit);
    tick(4);
    tests++; if (!hit) begin fails++; $display("FAIL prio_wait: got %0d acks want 2", ack_q.size()); end
    tests++; if (ack_q.size() != 2) begin fails++; $display("FAIL prio_count: got %0d want 2", ack_q.size()); end
    else begin
      tests++; if (ack_q[0] !== 2'b01 || ack_q[1] !== 2'b11) begin
        fails++; $display("FAIL prio_order: got %b,%b want 01,11", ack_q[0], ack_q[1]); end
    end
    tests++; if (aw_q.size() != 2) begin fails++; $display("FAIL prio_aw_count: got %0d want 2", aw_q.size()); end
    else begin
      tests++; if (aw_q[0] !== 32'hA000_0004 || aw_q[1] !== 32'hB000_0008) begin
        fails++; $display("FAIL prio_aw_order: got %h,%h want a0000004,b0000008", aw_q[0], aw_q[1]); end
    end
  endtask

  task automatic test_aw_delay();
    logic av[15], wv[15], br[15];
    int aw_hi, w_hi, aw_first, b_first, overlap;
    aw_delay = 3; w_delay = 0; b_delay = 0; resp_cfg = 2'b00;
    clear_mon();
    @(negedge clk);
    maestro_adress_i = 32'h0000_0040; maestro_data_i = 32'h55; maestro_req_i = 1'b1;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      av[i] = aw_valid; wv[i] = w_valid; br[i] = b_ready;
      maestro_req_i = 1'b0;
    end
    aw_hi = 0; w_hi = 0; aw_first = -1; b_first = -1; overlap = 0;
    for (int i = 0; i < 15; i++) begin
      if (av[i] === 1'b1) begin aw_hi++; if (aw_first < 0) aw_first = i; end
      if (wv[i] === 1'b1) w_hi++;
      if (br[i] === 1'b1 && b_first < 0) b_first = i;
      if (br[i] === 1'b1 && (av[i] === 1'b1 || wv[i] === 1'b1)) overlap++;
    end
    tests++; if (w_hi != 1) begin fails++; $display("FAIL awd_w_cycles: got %0d want 1", w_hi); end
    tests++; if (aw_hi != 4) begin fails++; $display("FAIL awd_aw_cycles: got %0d want 4", aw_hi); end
    tests++; if (overlap != 0 || b_first != aw_first + 4) begin
      fails++; $display("FAIL awd_b_ready: got first=%0d overlap=%0d want first=%0d overlap=0",
                        b_first, overlap, aw_first + 4); end
    tests++; if (ack_q.size() != 1) begin fails++; $display("FAIL awd_acks: got %0d want 1", ack_q.size()); end
  endtask

  task automatic test_error();
    bit hit;
    aw_delay = 0; w_delay = 0; b_delay = 0; resp_cfg = 2'b10;
    clear_mon();
    @(negedge clk);
    maestro_adress_i = 32'h0000_0100; maestro_data_i = 32'h7; maestro_req_i = 1'b1;
    @(negedge clk);
    maestro_req_i = 1'b0;
    wait_acks(1, 30, hit);
    tick(2);
    tests++; if (!hit || ack_q.size() != 1 || ack_q[0] !== 2'b00) begin
      fails++; $display("FAIL err_ack: got n=%0d first=%b want n=1 first=00", ack_q.size(),
                        (ack_q.size() > 0) ? ack_q[0] : 2'bxx); end
    tests++; if (err_o !== 1'b1) begin fails++; $display("FAIL err_set: got %b want 1", err_o); end
    // A later good write keeps err_o set.
    resp_cfg = 2'b00;
    clear_mon();
    fsm_adress_i = 32'h0000_0200; fsm_data_i = 32'h9; fsm_req_i = 1'b1;
    @(negedge clk);
    fsm_req_i = 1'b0;
    wait_acks(1, 30, hit);
    tick(2);
    tests++; if (!hit || ack_q.size() != 1 || ack_q[0] !== 2'b11) begin
      fails++; $display("FAIL err_good_ack: got n=%0d want n=1 first=11", ack_q.size()); end
    tests++; if (err_o !== 1'b1) begin fails++; $display("FAIL err_sticky: got %b want 1", err_o); end
  endtask

  task automatic test_timeout();
    int  rcnt;
    bit  seen;
    logic v;
    b_hang = 1'b1;
    rcnt = 0; seen = 1'b0; v = 1'bx;
    @(negedge clk);
    maestro_adress_i = 32'h0000_0300; maestro_data_i = 32'hA; maestro_req_i = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      maestro_req_i = 1'b0;
      if (b_ready === 1'b1) rcnt++;
      if (maestro_ack_o === 1'b1) begin seen = 1'b1; v = maestro_valid_o; break; end
    end
    tests++; if (!seen || v !== 1'b0) begin
      fails++; $display("FAIL to_ack: got seen=%0b valid=%b want seen=1 valid=0", seen, v); end
    tests++; if (rcnt != 4) begin fails++; $display("FAIL to_resp_cycles: got %0d want 4", rcnt); end
    b_hang = 1'b0;
    tick(3);
  endtask

  task automatic test_hold();
    bit hit;
    aw_delay = 0; w_delay = 0; b_delay = 0; resp_cfg = 2'b00;
    clear_mon();
    @(negedge clk);
    fsm_adress_i = 32'h0000_0400; fsm_data_i = 32'hB; fsm_req_i = 1'b1;
    tick(10);
    fsm_req_i = 1'b0;
    wait_acks(2, 15, hit);
    tests++; if (ack_q.size() != 1) begin fails++; $display("FAIL hold_acks: got %0d want 1", ack_q.size()); end
    tests++; if (aw_q.size() != 1) begin fails++; $display("FAIL hold_beats: got %0d want 1", aw_q.size()); end
  endtask

  task automatic test_reset_mid();
    bit hit, inresp;
    b_hang = 1'b1; inresp = 1'b0;
    clear_mon();
    @(negedge clk);
    maestro_adress_i = 32'h0000_0500; maestro_data_i = 32'hC; maestro_req_i = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      maestro_req_i = 1'b0;
      if (b_ready === 1'b1) begin inresp = 1'b1; break; end
    end
    tests++; if (!inresp) begin fails++; $display("FAIL rmid_resp: got b_ready=0 want 1"); end
    rst_n = 1'b0;
    @(negedge clk);
    tests++; if ({aw_valid, w_valid, b_ready, maestro_ack_o, maestro_valid_o, fsm_ack_o,
                  fsm_valid_o, err_o} !== 8'h00 || aw_addr !== 32'h0 || w_data !== 32'h0) begin
      fails++; $display("FAIL rmid_outputs: got ctl=%b%b%b%b%b%b%b%b addr=%h data=%h want all 0",
                        aw_valid, w_valid, b_ready, maestro_ack_o, maestro_valid_o, fsm_ack_o,
                        fsm_valid_o, err_o, aw_addr, w_data); end
    b_hang = 1'b0;
    clear_mon();
    rst_n = 1'b1;
    tick(10);
    tests++; if (ack_q.size() != 0) begin fails++; $display("FAIL rmid_no_ack: got %0d want 0", ack_q.size()); end
    maestro_adress_i = 32'h0000_0600; maestro_data_i = 32'hD; maestro_req_i = 1'b1;
    @(negedge clk);
    maestro_req_i = 1'b0;
    wait_acks(1, 30, hit);
    tick(2);
    tests++; if (ack_q.size() != 1 || aw_q.size() != 1 || ack_q[0] !== 2'b01 ||
                 aw_q[0] !== 32'h0000_0600) begin
      fails++; $display("FAIL rmid_fresh: got acks=%0d beats=%0d want 1 1 addr 600",
                        ack_q.size(), aw_q.size()); end
  endtask

  task automatic test_random();
    logic [31:0] ma, md, fa, fd;
    logic [31:0] ea[$], ed[$];
    logic [1:0]  ek[$];
    logic [1:0]  rc;
    bit          reedge, hit, okv, err_model;
    int          sel;
    err_model = 1'b0;  // reset_mid cleared err_o
    for (int it = 0; it < 30; it++) begin
      sel    = $urandom_range(0, 2);  // 0 maestro, 1 fsm, 2 both
      reedge = (sel == 2) && ($urandom_range(0, 1) == 1);
      ma = $urandom; md = $urandom; fa = $urandom; fd = $urandom;
      aw_delay = $urandom_range(0, 3);
      w_delay  = $urandom_range(0, 3);
      b_delay  = $urandom_range(0, 3);
      case ($urandom_range(0, 3))
        0, 1:    rc = 2'b00;
        2:       rc = 2'b10;
        default: rc = 2'b11;
      endcase
      resp_cfg = rc;
      okv = (rc == 2'b00);
      ea.delete(); ed.delete(); ek.delete();
      clear_mon();
      @(negedge clk);
      if (sel != 1) begin maestro_adress_i = ma; maestro_data_i = md; maestro_req_i = 1'b1; end
      if (sel != 0) begin fsm_adress_i = fa; fsm_data_i = fd; fsm_req_i = 1'b1; end
      @(negedge clk);
      maestro_req_i = 1'b0; fsm_req_i = 1'b0;
      if (reedge) begin
        // Second edge while still pending: newest values win, no extra write.
        @(negedge clk);
        fa = $urandom; fd = $urandom;
        fsm_adress_i = fa; fsm_data_i = fd; fsm_req_i = 1'b1;
        @(negedge clk);
        fsm_req_i = 1'b0;
      end
      if (sel != 1) begin ea.push_back(ma); ed.push_back(md); ek.push_back({1'b0, okv}); end
      if (sel != 0) begin ea.push_back(fa); ed.push_back(fd); ek.push_back({1'b1, okv}); end
      if (!okv) err_model = 1'b1;
      wait_acks(ek.size(), 80, hit);
      tick(4);
      tests++; if (!hit || ack_q.size() != ek.size()) begin
        fails++; $display("FAIL rnd%0d_acks: got %0d want %0d", it, ack_q.size(), ek.size()); end
      tests++; if (aw_q.size() != ea.size() || w_q.size() != ed.size()) begin
        fails++; $display("FAIL rnd%0d_beats: got aw=%0d w=%0d want %0d", it, aw_q.size(),
                          w_q.size(), ea.size()); end
      for (int i = 0; i < ek.size(); i++) begin
        tests++;
        if (i >= ack_q.size() || i >= aw_q.size() || i >= w_q.size()) begin
          fails++; $display("FAIL rnd%0d_txn%0d: missing, want port=%b valid=%b", it, i,
                            ek[i][1], ek[i][0]);
        end else if (ack_q[i] !== ek[i] || aw_q[i] !== ea[i] || w_q[i] !== ed[i]) begin
          fails++; $display("FAIL rnd%0d_txn%0d: got ack=%b addr=%h data=%h want ack=%b addr=%h data=%h",
                            it, i, ack_q[i], aw_q[i], w_q[i], ek[i], ea[i], ed[i]);
        end
      end
      tests++; if (err_o !== err_model) begin
        fails++; $display("FAIL rnd%0d_err: got %b want %b", it, err_o, err_model); end
    end
  endtask

  task automatic test_exclusive();
    tests++; if (viol != 0) begin fails++; $display("FAIL ack_exclusive: got %0d violations want 0", viol); end
  endtask

  initial begin
    rst_n = 1'b0;
    maestro_adress_i = '0; maestro_data_i = '0; maestro_req_i = 1'b0;
    fsm_adress_i = '0; fsm_data_i = '0; fsm_req_i = 1'b0;
    aw_ready = 1'b0; w_ready = 1'b0; b_valid = 1'b0; b_resp = 2'b00;
    test_reset();
    test_latency();
    test_priority();
    test_aw_delay();
    test_error();
    test_timeout();
    test_hold();
    test_reset_mid();
    test_random();
    test_exclusive();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
